// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for the N-bit universal up/down counter.
// Accepts timed commands over valid/ready and drives the counter control
// pins for an exact number of cycles; UNTIL ops stop on the terminal flag.
module counter_cmd_sequencer #(
    parameter int unsigned N  = 8,
    parameter int unsigned TW = 8
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [2:0]    cmd_op_i,
    input  logic [TW-1:0] cmd_ticks_i,
    input  logic [N-1:0]  cmd_data_i,
    input  logic          cnt_max_i,
    input  logic          cnt_min_i,
    output logic          cnt_en_o,
    output logic          cnt_up_o,
    output logic          cnt_down_o,
    output logic          cnt_load_o,
    output logic          cnt_preset_o,
    output logic          cnt_reset_o,
    output logic [N-1:0]  cnt_l_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          hit_o
);

    localparam logic [2:0] OP_HOLD    = 3'd0;
    localparam logic [2:0] OP_UP      = 3'd1;
    localparam logic [2:0] OP_DOWN    = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_PRESET  = 3'd4;
    localparam logic [2:0] OP_CLEAR   = 3'd5;
    localparam logic [2:0] OP_UP_MAX  = 3'd6;
    localparam logic [2:0] OP_DN_MIN  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic [TW-1:0]   rem_q;
    logic [TW-1:0]   rem_d;
    logic [TW-1:0]   ticks_eff_d;
    logic [N-1:0]    l_data_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            hit_q;
    logic            en_q;
    logic            up_q;
    logic            down_q;
    logic            load_q;
    logic            preset_q;
    logic            clear_q;
    logic            term_c;
    logic            last_c;
    logic [5:0]      ctl_d;

    // Control pin decode for an opcode: {en, up, down, load, preset, clear}
    function automatic logic [5:0] decode_ctl(input logic [2:0] op);
        logic [5:0] v;
        v = 6'b000000;
        case (op)
            OP_HOLD:   v = 6'b000000;
            OP_UP:     v = 6'b110000;
            OP_DOWN:   v = 6'b101000;
            OP_LOAD:   v = 6'b100100;
            OP_PRESET: v = 6'b100010;
            OP_CLEAR:  v = 6'b000001;
            OP_UP_MAX: v = 6'b110000;
            OP_DN_MIN: v = 6'b101000;
            default:   v = 6'b000000;
        endcase
        return v;
    endfunction

    // Effective run length at accept: zero means one, single-shot ops run once
    always_comb begin
        ticks_eff_d = (cmd_ticks_i == '0) ? TW'(1) : cmd_ticks_i;
        if (cmd_op_i == OP_LOAD || cmd_op_i == OP_PRESET || cmd_op_i == OP_CLEAR) begin
            ticks_eff_d = TW'(1);
        end
        ctl_d = decode_ctl(cmd_op_i);
        rem_d = rem_q - TW'(1);
    end

    // Terminal flag of the latched UNTIL op and the last-RUN-cycle condition
    assign term_c = ((op_q == OP_UP_MAX) && cnt_max_i) ||
                    ((op_q == OP_DN_MIN) && cnt_min_i);
    assign last_c = (rem_q == TW'(1)) || term_c;

    // Sequencer FSM with registered control, handshake and status outputs
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            op_q     <= OP_HOLD;
            rem_q    <= '0;
            l_data_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            en_q     <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            load_q   <= 1'b0;
            preset_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    hit_q  <= 1'b0;
                    if (cmd_valid_i && ready_q) begin
                        state_q  <= RUN;
                        op_q     <= cmd_op_i;
                        l_data_q <= cmd_data_i;
                        rem_q    <= ticks_eff_d;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        {en_q, up_q, down_q, load_q, preset_q, clear_q} <= ctl_d;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    if (last_c) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        hit_q   <= term_c;
                        {en_q, up_q, down_q, load_q, preset_q, clear_q} <= 6'b000000;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    hit_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    hit_q   <= 1'b0;
                    {en_q, up_q, down_q, load_q, preset_q, clear_q} <= 6'b000000;
                end
            endcase
        end
    end

    // UNTIL ops gate the enable directly from the flag so the counter never wraps
    assign cnt_en_o     = en_q && !term_c;
    assign cnt_up_o     = up_q;
    assign cnt_down_o   = down_q;
    assign cnt_load_o   = load_q;
    assign cnt_preset_o = preset_q;
    assign cnt_reset_o  = clear_q;
    assign cnt_l_data_o = l_data_q;
    assign cmd_ready_o  = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign hit_o        = hit_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer with a behavioural counter attached.
module tb_counter_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_ticks;
    logic [7:0] cmd_data;
    logic       cnt_max, cnt_min;
    logic       cnt_en, cnt_up, cnt_down, cnt_load, cnt_preset, cnt_reset;
    logic [7:0] cnt_l_data;
    logic       busy, done, hit;
    logic [7:0] count = 8'd0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] ticks;
        logic [7:0] data;
        int         exp_run;
        int         exp_en;
        logic [7:0] exp_count;
        logic       exp_hit;
    } vec_t;

    vec_t vecs[16];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    counter_cmd_sequencer #(.N(8), .TW(8)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_ticks_i  (cmd_ticks),
        .cmd_data_i   (cmd_data),
        .cnt_max_i    (cnt_max),
        .cnt_min_i    (cnt_min),
        .cnt_en_o     (cnt_en),
        .cnt_up_o     (cnt_up),
        .cnt_down_o   (cnt_down),
        .cnt_load_o   (cnt_load),
        .cnt_preset_o (cnt_preset),
        .cnt_reset_o  (cnt_reset),
        .cnt_l_data_o (cnt_l_data),
        .busy_o       (busy),
        .done_o       (done),
        .hit_o        (hit)
    );

    // Universal counter model driven by the sequencer
    always @(posedge clk) begin
        if (cnt_reset)
            count <= 8'd0;
        else if (cnt_en) begin
            if (cnt_load)        count <= cnt_l_data;
            else if (cnt_preset) count <= 8'hFF;
            else if (cnt_up)     count <= count + 8'd1;
            else if (cnt_down)   count <= count - 8'd1;
        end
    end
    assign cnt_max = (count == 8'hFF);
    assign cnt_min = (count == 8'h00);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one command, watch its RUN window and check against the scoreboard
    task automatic run_cmd(input vec_t v, input int idx);
        vec_t e;
        int run_n, en_n, ctl_bad, guard;
        logic [5:0] exp_ctl, act_ctl;
        logic exp_en;
        exp_q.push_back(v);
        run_n = 0; en_n = 0; ctl_bad = 0; guard = 0;
        chk($sformatf("v%0d_ready_idle", idx), int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_ticks = v.ticks; cmd_data = v.data;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_ticks = 8'd0; cmd_data = 8'd0;
        while (!done && guard < 600) begin
            if (busy) begin
                run_n++;
                if (cnt_en) en_n++;
                case (v.op)
                    3'd1, 3'd2, 3'd3, 3'd4: exp_en = 1'b1;
                    3'd6:                   exp_en = !cnt_max;
                    3'd7:                   exp_en = !cnt_min;
                    default:                exp_en = 1'b0;
                endcase
                exp_ctl = {exp_en, (v.op == 3'd1 || v.op == 3'd6), (v.op == 3'd2 || v.op == 3'd7),
                           (v.op == 3'd3), (v.op == 3'd4), (v.op == 3'd5)};
                act_ctl = {cnt_en, cnt_up, cnt_down, cnt_load, cnt_preset, cnt_reset};
                if (act_ctl != exp_ctl || cmd_ready) ctl_bad++;
            end
            guard++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_timeout", idx), int'(guard >= 600), 0);
        e = exp_q.pop_front();
        chk($sformatf("v%0d_run_cycles", idx), run_n, e.exp_run);
        chk($sformatf("v%0d_en_cycles", idx), en_n, e.exp_en);
        chk($sformatf("v%0d_ctl_errs", idx), ctl_bad, 0);
        chk($sformatf("v%0d_hit", idx), int'(hit), int'(e.exp_hit));
        chk($sformatf("v%0d_count", idx), int'(count), int'(e.exp_count));
        chk($sformatf("v%0d_done_ctl_idle", idx),
            int'({busy, cmd_ready, cnt_en, cnt_up, cnt_down, cnt_load, cnt_preset, cnt_reset}), 8'b1000_0000);
        @(negedge clk);
        chk($sformatf("v%0d_post_done", idx), int'({cmd_ready, busy, done, hit}), 4'b1000);
    endtask

    initial begin
        vecs[0]  = '{3'd1, 8'd10,  8'd0,   10,  10,  8'd10,  1'b0};
        vecs[1]  = '{3'd3, 8'd7,   8'd50,  1,   1,   8'd50,  1'b0};
        vecs[2]  = '{3'd2, 8'd10,  8'd0,   10,  10,  8'd40,  1'b0};
        vecs[3]  = '{3'd3, 8'd0,   8'd250, 1,   1,   8'd250, 1'b0};
        vecs[4]  = '{3'd6, 8'd255, 8'd0,   6,   5,   8'd255, 1'b1};
        vecs[5]  = '{3'd5, 8'd9,   8'd0,   1,   0,   8'd0,   1'b0};
        vecs[6]  = '{3'd7, 8'd5,   8'd0,   1,   0,   8'd0,   1'b1};
        vecs[7]  = '{3'd0, 8'd0,   8'd0,   1,   0,   8'd0,   1'b0};
        vecs[8]  = '{3'd4, 8'd3,   8'd0,   1,   1,   8'd255, 1'b0};
        vecs[9]  = '{3'd6, 8'd4,   8'd0,   1,   0,   8'd255, 1'b1};
        vecs[10] = '{3'd7, 8'd3,   8'd0,   3,   3,   8'd252, 1'b0};
        vecs[11] = '{3'd3, 8'd1,   8'd2,   1,   1,   8'd2,   1'b0};
        vecs[12] = '{3'd7, 8'd2,   8'd0,   2,   2,   8'd0,   1'b0};
        vecs[13] = '{3'd3, 8'd1,   8'd1,   1,   1,   8'd1,   1'b0};
        vecs[14] = '{3'd7, 8'd2,   8'd0,   2,   1,   8'd0,   1'b1};
        vecs[15] = '{3'd1, 8'd255, 8'd0,   255, 255, 8'd255, 1'b0};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_ticks = 8'd0; cmd_data = 8'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state",
            int'({cmd_ready, busy, done, hit, cnt_en, cnt_up, cnt_down, cnt_load, cnt_preset, cnt_reset}),
            10'b10_0000_0000);
        chk("reset_l_data", int'(cnt_l_data), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_cmd(vecs[i], i);

        // cmd_valid held through a busy command is taken only once back in IDLE
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_ticks = 8'd0;
        @(negedge clk);
        cmd_op = 3'd5; cmd_ticks = 8'd4;
        chk("hold_run", int'({busy, done, cmd_ready, cnt_reset}), 4'b1000);
        @(negedge clk);
        chk("hold_done", int'({busy, done, cmd_ready, cnt_reset}), 4'b1100);
        @(negedge clk);
        chk("held_valid_idle", int'({busy, done, cmd_ready, cnt_reset}), 4'b0010);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("clear_run", int'({busy, done, cmd_ready, cnt_reset, cnt_en}), 5'b10010);
        @(negedge clk);
        chk("clear_done", int'({busy, done, cnt_reset}), 3'b110);
        chk("clear_count", int'(count), 0);
        @(negedge clk);

        // Reset in the middle of UP ticks=20 aborts with no done pulse
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_ticks = 8'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("mid_count_before", int'(count), 7);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_outputs",
            int'({cmd_ready, busy, done, hit, cnt_en, cnt_up, cnt_down, cnt_load, cnt_preset, cnt_reset}),
            10'b10_0000_0000);
        chk("abort_count", int'(count), 8);
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done || busy) seen_done++;
            end
            chk("abort_no_done", seen_done, 0);
        end
        chk("abort_count_frozen", int'(count), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
